sqrt_nr_seq: RTL and testbench
==============================

Name: sqrt_nr_seq

Overview:
- Multi-cycle, parametrised, non-restoring integer square root with valid/ready handshakes on input and output.
- Sequential successor to the team's single-cycle combinational square-root unit.
- Retires ITERS_PER_CYCLE root bits per clock, trading latency for area/timing. Used wherever a WIDTH-bit radicand needs an exact root and remainder under a shared clock.

Parameters:
- WIDTH, 32, radicand width in bits. Must be even and ≥4.
- ITERS_PER_CYCLE, 1, non-restoring iterations per clock. Must divide WIDTH/2.
- Derived constants:
  - QW = WIDTH/2 (root width).
  - RW = QW+1 (remainder width).
  - STEPS = QW/ITERS_PER_CYCLE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  radicand valid.
- in_ready  out  1  block can accept a radicand.
- in_data  in  WIDTH  unsigned radicand D.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_root  out  QW  floor(sqrt(D)).
- out_rem  out  RW  D − out_root², range 0..2·out_root.
- busy  out  1  high in CALC or FIX.
- out_root_rnd  out  QW+1  root rounded to nearest; present only with SQRT_ROUND_EN.

Behaviour:
- Reset is asynchronous on rst_n low. It forces:
  - state = IDLE.
  - in_ready = 1, out_valid = 0, busy = 0.
  - out_root, out_rem and all internal registers = 0.
  - Any operation in flight is discarded with no output.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch in_data into the D register, clear q and r, set step counter to STEPS−1, go to CALC.
- CALC, each cycle:
  - Apply ITERS_PER_CYCLE chained iterations, consuming radicand bit-pairs MSB first.
  - Per iteration:
    - r = (r<<2)|next2bits.
    - If r ≥ 0: r −= {q,2'b01}; otherwise r += {q,2'b11}.
    - Then q = (q<<1)|(r ≥ 0).
  - r is a signed register of RW+1 bits, with sign-extended arithmetic.
  - When the counter reaches 0, go to FIX; otherwise decrement the counter.
- FIX, one cycle:
  - If r < 0: r += {q,1'b1}.
  - Register out_root = q and out_rem = r[RW−1:0].
  - Go to DONE.
- DONE:
  - out_valid = 1; out_root and out_rem are held stable.
  - On out_ready, go to IDLE. out_valid drops the next cycle.
  - in_ready = 0 in DONE, so no overlap with the next accept.
- Latency: out_valid rises exactly STEPS+1 cycles after the accepting edge. This is 17 cycles at the defaults.
- Throughput is one result per STEPS+3 cycles when out_ready is held high.
- in_ready is low in CALC, FIX and DONE. in_valid in those states is ignored and not queued.
- out_ready while out_valid = 0 has no effect.
- Values are unsigned throughout. D = 0 gives root 0, rem 0. D = 2^WIDTH−1 gives root 2^QW−1, rem 2^(QW+1)−2.
- Outputs are registered; there is no combinational path from in_* to out_*.

Optional Feature:
- Macro: SQRT_ROUND_EN.
- With the macro:
  - The out_root_rnd port exists.
  - It is registered in FIX as q + (r_corrected > q), which gives round-to-nearest. Exact halves cannot occur for integers.
  - It is QW+1 bits wide, because the maximum radicand rounds to 2^QW.
- Without the macro, the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package sqrt_pkg holds:
  - The state enum typedef (IDLE, CALC, FIX, DONE).
  - Localparam-computable width functions: qw(WIDTH), rw(WIDTH), steps(WIDTH, ITERS).
- Sub-module sqrt_nr_step is purely combinational and performs one non-restoring iteration.
  - Inputs: q, r, 2-bit pair. Outputs: q', r'.
  - Parametrised by QW.
  - The top instantiates ITERS_PER_CYCLE copies in a generate chain.

Test Plan:
- Defaults, known values:
  - D = 0 → root 0, rem 0.
  - D = 15 → root 3, rem 6 (out_root_rnd 4 with the macro).
  - D = 1048576 → root 1024, rem 0.
  - D = 4294705156 → root 65534, rem 0.
  - D = 4294967295 → root 65535, rem 131070 (out_root_rnd 65536).
- Latency and handshake: accept at cycle t → out_valid first high at t+17. Hold out_ready = 0 for 5 cycles → outputs stable and in_ready = 0 throughout. Pulse in_valid during CALC → ignored.
- Back-to-back with out_ready = 1 constantly, D = 100 then 169 → roots 10 and 13, rem 0. The second accept occurs at the cycle after the first out_valid.
- Reset mid-operation: assert rst_n = 0 asynchronously at CALC step 5 → out_valid, busy and the outputs go to 0 immediately. After release, D = 9 → root 3, rem 0.
- ITERS_PER_CYCLE = 4, D = 40000 → root 200, rem 0, out_valid at accept + 5 cycles.
- WIDTH = 8, ITERS_PER_CYCLE = 2: sweep D = 0..255 exhaustively → root² ≤ D < (root+1)² and rem = D − root².

Source files
------------

// File: rtl/sqrt_pkg.sv
// ---------------------------------------------------------------------------
// sqrt_pkg
// Shared definitions for the sequential non-restoring square-root unit.
//   sqrt_state_t : FSM state encoding (IDLE, CALC, FIX, DONE)
//   qw(w)        : root width for a w-bit radicand (w/2)
//   rw(w)        : remainder width for a w-bit radicand (w/2 + 1)
//   steps(w, i)  : CALC cycles needed when retiring i root bits per clock
//   cnt_w(n)     : counter width able to hold 0..n-1 (at least 1 bit)
// ---------------------------------------------------------------------------
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } sqrt_state_t;

  function automatic int qw(input int width);
    return width / 2;
  endfunction

  function automatic int rw(input int width);
    return width / 2 + 1;
  endfunction

  function automatic int steps(input int width, input int iters);
    return (width / 2) / iters;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sqrt_nr_step.sv
// ---------------------------------------------------------------------------
// sqrt_nr_step
// One purely combinational non-restoring square-root iteration.
//   q_in  [QW-1:0] : partial root so far
//   r_in  [QW+1:0] : partial remainder, two's complement (MSB = sign)
//   pair  [1:0]    : next radicand bit-pair, MSB-first order
//   q_out [QW-1:0] : partial root with one more bit appended
//   r_out [QW+1:0] : updated partial remainder
// The remainder of a non-restoring square root stays inside
// [-(2q+1), 2q], so QW+2 bits of modular arithmetic are exact even though
// the intermediate (r<<2)|pair may wrap before the add/subtract.
// ---------------------------------------------------------------------------
module sqrt_nr_step #(
  parameter int QW = 16
) (
  input  logic [QW-1:0] q_in,
  input  logic [QW+1:0] r_in,
  input  logic [1:0]    pair,
  output logic [QW-1:0] q_out,
  output logic [QW+1:0] r_out
);

  logic [QW+1:0] r_shift;

  always_comb begin
    r_shift = (r_in << 2) | {{QW{1'b0}}, pair};
    // Sign of the previous remainder picks subtract {q,01} or add {q,11}.
    if (r_in[QW+1] == 1'b0) begin
      r_out = r_shift - {q_in, 2'b01};
    end else begin
      r_out = r_shift + {q_in, 2'b11};
    end
    q_out = {q_in[QW-2:0], ~r_out[QW+1]};
  end

endmodule

// File: rtl/sqrt_nr_seq.sv
// ---------------------------------------------------------------------------
// sqrt_nr_seq
// Multi-cycle non-restoring integer square root, ITERS_PER_CYCLE root bits
// per clock.
//
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready : radicand handshake, in_data = unsigned radicand D
//   out_valid/out_ready : result handshake
//   out_root          : floor(sqrt(D))
//   out_rem           : D - out_root^2 (0 .. 2*out_root)
//   busy              : high while the FSM is in CALC or FIX
//   out_root_rnd      : root rounded to nearest (only with SQRT_ROUND_EN)
//   state_dbg         : current FSM state for observation
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. A producer holding valid keeps its data
// stable until that edge; ready carries no obligation and may be dropped at
// any time. in_ready is high only in IDLE; out_valid is high only in DONE.
//
// Optional feature macro: SQRT_ROUND_EN adds the out_root_rnd port.
//
// Parameter legality: WIDTH even and >= 4, ITERS_PER_CYCLE divides WIDTH/2.
// ---------------------------------------------------------------------------
module sqrt_nr_seq
  import sqrt_pkg::*;
#(
  parameter int  WIDTH           = 32,
  parameter int  ITERS_PER_CYCLE = 1,
  localparam int QW              = qw(WIDTH),
  localparam int RW              = rw(WIDTH),
  localparam int STEPS           = steps(WIDTH, ITERS_PER_CYCLE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    out_root,
  output logic [RW-1:0]    out_rem,
  output logic             busy,
`ifdef SQRT_ROUND_EN
  output logic [QW:0]      out_root_rnd,
`endif
  output sqrt_state_t      state_dbg
);

  localparam int CW = cnt_w(STEPS);

  sqrt_state_t      state;
  logic [WIDTH-1:0] d_reg;   // radicand, shifted left as pairs are consumed
  logic [QW-1:0]    q_reg;
  logic [RW:0]      r_reg;   // signed partial remainder (MSB = sign)
  logic [CW-1:0]    cnt;

  // Chain of ITERS_PER_CYCLE iterations evaluated in one clock.
  logic [QW-1:0] q_chain [ITERS_PER_CYCLE+1];
  logic [RW:0]   r_chain [ITERS_PER_CYCLE+1];

  assign q_chain[0] = q_reg;
  assign r_chain[0] = r_reg;

  for (genvar i = 0; i < ITERS_PER_CYCLE; i++) begin : g_step
    sqrt_nr_step #(
      .QW (QW)
    ) u_step (
      .q_in  (q_chain[i]),
      .r_in  (r_chain[i]),
      .pair  (d_reg[WIDTH-1-2*i -: 2]),
      .q_out (q_chain[i+1]),
      .r_out (r_chain[i+1])
    );
  end

  // Final correction: a negative remainder means the last trial subtraction
  // overshot, so add back 2q+1. The corrected value fits in RW bits, so the
  // addition is done modulo 2^RW.
  logic [RW-1:0] r_fix;
  assign r_fix = r_reg[RW-1:0] + (r_reg[RW] ? {q_reg, 1'b1} : {RW{1'b0}});

`ifdef SQRT_ROUND_EN
  // Round to nearest: sqrt(D) >= q + 0.5 exactly when rem > q.
  logic [QW:0] root_rnd;
  assign root_rnd = {1'b0, q_reg} + {{QW{1'b0}}, (r_fix > {1'b0, q_reg})};
`endif

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      d_reg        <= '0;
      q_reg        <= '0;
      r_reg        <= '0;
      cnt          <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      out_root     <= '0;
      out_rem      <= '0;
`ifdef SQRT_ROUND_EN
      out_root_rnd <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            d_reg    <= in_data;
            q_reg    <= '0;
            r_reg    <= '0;
            cnt      <= CW'(STEPS - 1);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end

        CALC: begin
          q_reg <= q_chain[ITERS_PER_CYCLE];
          r_reg <= r_chain[ITERS_PER_CYCLE];
          d_reg <= d_reg << (2 * ITERS_PER_CYCLE);
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        FIX: begin
          r_reg        <= {1'b0, r_fix};
          out_root     <= q_reg;
          out_rem      <= r_fix;
`ifdef SQRT_ROUND_EN
          out_root_rnd <= root_rnd;
`endif
          busy         <= 1'b0;
          out_valid    <= 1'b1;
          state        <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_nr_seq.sv
// ---------------------------------------------------------------------------
// tb_sqrt_nr_seq
// Bench for sqrt_nr_seq with three instances:
//   u_main : defaults (WIDTH 32, 1 iteration/clock)
//   u_i4   : WIDTH 32, 4 iterations/clock
//   u_w8   : WIDTH 8, 2 iterations/clock, exhaustive radicand sweep
// Define SQRT_ROUND_EN to also connect and check out_root_rnd.
// ---------------------------------------------------------------------------
module tb_sqrt_nr_seq;
  import sqrt_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters / scoreboards ----------------
  int n_cmp;
  int n_bad;

  logic [63:0] exp_q[$];
  logic [63:0] i4_q[$];
  logic [63:0] w8_q[$];

  int m_acc_cyc;
  int i4_acc;
  int w8_acc;

  // ---------------- main DUT ----------------
  logic        m_in_valid;
  logic        m_in_ready;
  logic [31:0] m_in_data;
  logic        m_out_valid;
  logic        m_out_ready;
  logic [15:0] m_root;
  logic [16:0] m_rem;
  logic        m_busy;
  sqrt_state_t m_state;
`ifdef SQRT_ROUND_EN
  logic [16:0] m_rnd;
`endif

  sqrt_nr_seq #(.WIDTH(32), .ITERS_PER_CYCLE(1)) u_main (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (m_in_valid),
    .in_ready     (m_in_ready),
    .in_data      (m_in_data),
    .out_valid    (m_out_valid),
    .out_ready    (m_out_ready),
    .out_root     (m_root),
    .out_rem      (m_rem),
    .busy         (m_busy),
`ifdef SQRT_ROUND_EN
    .out_root_rnd (m_rnd),
`endif
    .state_dbg    (m_state)
  );

  // ---------------- 4 iterations per clock ----------------
  logic        i4_in_valid;
  logic        i4_in_ready;
  logic [31:0] i4_in_data;
  logic        i4_out_valid;
  logic        aux_out_ready;
  logic [15:0] i4_root;
  logic [16:0] i4_rem;
  logic        i4_busy;
  sqrt_state_t i4_state;
`ifdef SQRT_ROUND_EN
  logic [16:0] i4_rnd;
`endif

  sqrt_nr_seq #(.WIDTH(32), .ITERS_PER_CYCLE(4)) u_i4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (i4_in_valid),
    .in_ready     (i4_in_ready),
    .in_data      (i4_in_data),
    .out_valid    (i4_out_valid),
    .out_ready    (aux_out_ready),
    .out_root     (i4_root),
    .out_rem      (i4_rem),
    .busy         (i4_busy),
`ifdef SQRT_ROUND_EN
    .out_root_rnd (i4_rnd),
`endif
    .state_dbg    (i4_state)
  );

  // ---------------- 8-bit, 2 iterations per clock ----------------
  logic        w8_in_valid;
  logic        w8_in_ready;
  logic [7:0]  w8_in_data;
  logic        w8_out_valid;
  logic [3:0]  w8_root;
  logic [4:0]  w8_rem;
  logic        w8_busy;
  sqrt_state_t w8_state;
`ifdef SQRT_ROUND_EN
  logic [4:0]  w8_rnd;
`endif

  sqrt_nr_seq #(.WIDTH(8), .ITERS_PER_CYCLE(2)) u_w8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (w8_in_valid),
    .in_ready     (w8_in_ready),
    .in_data      (w8_in_data),
    .out_valid    (w8_out_valid),
    .out_ready    (aux_out_ready),
    .out_root     (w8_root),
    .out_rem      (w8_rem),
    .busy         (w8_busy),
`ifdef SQRT_ROUND_EN
    .out_root_rnd (w8_rnd),
`endif
    .state_dbg    (w8_state)
  );

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
  endtask

  // ---------------- driver tasks ----------------
  // All drivers change inputs at posedge+1 so the negedge monitors see
  // settled values.
  task automatic send_main(input logic [31:0] d, input logic [15:0] er,
                           input logic [16:0] em, input logic [16:0] ernd);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    while (!m_in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!m_in_ready) begin
      fail("main_accept_timeout");
      return;
    end
    exp_q.push_back({14'd0, ernd, er, em});
    m_in_valid = 1'b1;
    m_in_data  = d;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    m_acc_cyc  = cyc;
  endtask

  task automatic send_i4(input logic [31:0] d, input logic [15:0] er, input logic [16:0] em);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    while (!i4_in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!i4_in_ready) begin
      fail("i4_accept_timeout");
      return;
    end
    i4_q.push_back({31'd0, er, em});
    i4_in_valid = 1'b1;
    i4_in_data  = d;
    @(posedge clk); #1;
    i4_in_valid = 1'b0;
    i4_acc      = cyc;
  endtask

  task automatic send_w8(input logic [7:0] d);
    int guard;
    int root;
    guard = 0;
    // Reference: largest root whose square does not exceed d.
    root = 0;
    while ((root + 1) * (root + 1) <= int'(d)) root++;
    @(posedge clk); #1;
    while (!w8_in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!w8_in_ready) begin
      fail("w8_accept_timeout");
      return;
    end
    w8_q.push_back({47'd0, d, 4'(root), 5'(int'(d) - root * root)});
    w8_in_valid = 1'b1;
    w8_in_data  = d;
    @(posedge clk); #1;
    w8_in_valid = 1'b0;
    w8_acc      = cyc;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || i4_q.size() != 0 || w8_q.size() != 0) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0 || i4_q.size() != 0 || w8_q.size() != 0) begin
      fail(name);
      exp_q.delete();
      i4_q.delete();
      w8_q.delete();
    end
  endtask

  // ---------------- monitors ----------------
  initial begin : mon_main
    logic        prev_v;
    logic [63:0] e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (m_out_valid && !prev_v) begin
        if (exp_q.size() == 0) fail("main_unexpected_result");
        else check("main_latency", 64'(cyc - m_acc_cyc), 64'd17);
      end
      if (m_out_valid && m_out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("main_root", 64'(m_root), 64'(e[32:17]));
        check("main_rem", 64'(m_rem), 64'(e[16:0]));
`ifdef SQRT_ROUND_EN
        check("main_root_rnd", 64'(m_rnd), 64'(e[49:33]));
`endif
      end
      prev_v = m_out_valid;
    end
  end

  initial begin : mon_i4
    logic        prev_v;
    logic [63:0] e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (i4_out_valid && !prev_v) begin
        if (i4_q.size() == 0) fail("i4_unexpected_result");
        else begin
          e = i4_q.pop_front();
          check("i4_latency", 64'(cyc - i4_acc), 64'd5);
          check("i4_root", 64'(i4_root), 64'(e[32:17]));
          check("i4_rem", 64'(i4_rem), 64'(e[16:0]));
        end
      end
      prev_v = i4_out_valid;
    end
  end

  initial begin : mon_w8
    logic        prev_v;
    logic [63:0] e;
    int          r;
    int          d;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (w8_out_valid && !prev_v) begin
        if (w8_q.size() == 0) fail("w8_unexpected_result");
        else begin
          e = w8_q.pop_front();
          r = int'(w8_root);
          d = int'(e[16:9]);
          check("w8_latency", 64'(cyc - w8_acc), 64'd3);
          check("w8_root", 64'(w8_root), 64'(e[8:5]));
          check("w8_rem", 64'(w8_rem), 64'(e[4:0]));
          check("w8_bound", 64'((r * r <= d) && ((r + 1) * (r + 1) > d)), 64'd1);
        end
      end
      prev_v = w8_out_valid;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int a1;
    int a2;
    int guard;
    n_cmp         = 0;
    n_bad         = 0;
    m_acc_cyc     = 0;
    i4_acc        = 0;
    w8_acc        = 0;
    rst_n         = 1'b0;
    m_in_valid    = 1'b0;
    m_in_data     = '0;
    m_out_ready   = 1'b1;
    i4_in_valid   = 1'b0;
    i4_in_data    = '0;
    w8_in_valid   = 1'b0;
    w8_in_data    = '0;
    aux_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(m_in_ready), 64'd1);
    check("rst_out_valid", 64'(m_out_valid), 64'd0);
    check("rst_busy", 64'(m_busy), 64'd0);
    check("rst_root", 64'(m_root), 64'd0);
    check("rst_rem", 64'(m_rem), 64'd0);
    check("rst_state", 64'(m_state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Known values; in_valid pulsed during CALC of D=15 must be ignored.
    send_main(32'd0, 16'd0, 17'd0, 17'd0);
    send_main(32'd15, 16'd3, 17'd6, 17'd4);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("calc_busy", 64'(m_busy), 64'd1);
    check("calc_in_ready", 64'(m_in_ready), 64'd0);
    m_in_valid = 1'b1;
    m_in_data  = 32'd12345;
    repeat (2) begin
      @(posedge clk); #1;
    end
    m_in_valid = 1'b0;
    send_main(32'd4294705156, 16'd65534, 17'd0, 17'd65534);
    send_main(32'd4294967295, 16'd65535, 17'd131070, 17'd65536);
    drain("drain_known");

    // Hold the result with out_ready low for 5 cycles.
    m_out_ready = 1'b0;
    send_main(32'd1048576, 16'd1024, 17'd0, 17'd1024);
    guard = 0;
    while (!m_out_valid && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!m_out_valid) fail("hold_wait_valid");
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_out_valid", 64'(m_out_valid), 64'd1);
      check("hold_in_ready", 64'(m_in_ready), 64'd0);
      check("hold_root", 64'(m_root), 64'd1024);
      check("hold_rem", 64'(m_rem), 64'd0);
    end
    check("hold_state", 64'(m_state), 64'(DONE));
    check("hold_busy", 64'(m_busy), 64'd0);
    m_out_ready = 1'b1;
    drain("drain_hold");

    // Back-to-back with out_ready held high.
    send_main(32'd100, 16'd10, 17'd0, 17'd10);
    a1 = m_acc_cyc;
    send_main(32'd169, 16'd13, 17'd0, 17'd13);
    a2 = m_acc_cyc;
    check("b2b_accept_gap", 64'(a2 - a1), 64'd19);
    drain("drain_b2b");

    // Asynchronous reset during CALC step 5.
    send_main(32'd4294967295, 16'd65535, 17'd131070, 17'd65536);
    repeat (5) @(posedge clk);
    #2;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(m_out_valid), 64'd0);
    check("arst_busy", 64'(m_busy), 64'd0);
    check("arst_root", 64'(m_root), 64'd0);
    check("arst_rem", 64'(m_rem), 64'd0);
    check("arst_in_ready", 64'(m_in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send_main(32'd9, 16'd3, 17'd0, 17'd3);
    drain("drain_after_reset");

    // Four iterations per clock.
    send_i4(32'd40000, 16'd200, 17'd0);
    send_i4(32'd4294967295, 16'd65535, 17'd131070);
    drain("drain_i4");

    // Exhaustive 8-bit sweep.
    for (int d = 0; d < 256; d++) begin
      send_w8(8'(d));
    end
    drain("drain_w8");

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
